// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
// Sequencing controller for an 18-word x 16-bit serial-in/parallel-out
// array shifter. Words arrive over a valid/ready handshake. Each accepted
// word is forwarded to the shifter with a one-cycle enable. After WORDS
// shifts the shifter contents are declared a complete frame. The frame is
// held frozen until the consumer takes it, and then the controller refills.
module sipo_frame_ctrl #(
    parameter int WORDS = 18,
    parameter int DW    = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [DW-1:0] sh_data,
    output logic          sh_en,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [CW-1:0] word_cnt,
    output logic [15:0]   frame_count
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_wordCnt;
    logic [CW-1:0] w_nextWordCnt;
    logic          r_frameValid;
    logic          w_nextFrameValid;
    logic [15:0]   r_frameCount;
    logic          w_handoff;
    logic          w_accept;
    logic          w_ready;

    // Handshake and shifter drive: purely combinational so the shifter captures on the controller's edge
    always_comb begin
        w_ready  = 1'b0;
        w_accept = 1'b0;
        w_ready  = (r_state == FILL) & ~flush & ~rst;
        w_accept = in_valid & w_ready;
    end

    assign in_ready    = w_ready;
    assign sh_en       = w_accept;
    assign sh_data     = in_data;
    assign frame_valid = r_frameValid;
    assign word_cnt    = r_wordCnt;
    assign frame_count = r_frameCount;

    // Next-state logic: flush overrides everything, including a simultaneous handoff
    always_comb begin
        w_nextState      = r_state;
        w_nextWordCnt    = r_wordCnt;
        w_nextFrameValid = r_frameValid;
        w_handoff        = 1'b0;
        if (flush) begin
            w_nextState      = FILL;
            w_nextWordCnt    = '0;
            w_nextFrameValid = 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (r_wordCnt == CW'(WORDS - 1)) begin
                            w_nextWordCnt    = CW'(WORDS);
                            w_nextState      = FULL;
                            w_nextFrameValid = 1'b1;
                        end else begin
                            w_nextWordCnt = r_wordCnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (r_frameValid && frame_ready) begin
                        w_nextState      = FILL;
                        w_nextWordCnt    = '0;
                        w_nextFrameValid = 1'b0;
                        w_handoff        = 1'b1;
                    end
                end
                default: begin
                    w_nextState      = FILL;
                    w_nextWordCnt    = '0;
                    w_nextFrameValid = 1'b0;
                end
            endcase
        end
    end

    // State, word counter and frame flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_wordCnt    <= '0;
            r_frameValid <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_wordCnt    <= w_nextWordCnt;
            r_frameValid <= w_nextFrameValid;
        end
    end

    // Completed-frame counter: wraps modulo 2^16 and only moves on a real handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameCount <= 16'd0;
        end else if (w_handoff) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl
// Directed bench for sipo_frame_ctrl. It includes a behavioural 288-bit
// shifter that is fed from the DUT's sh_en/sh_data outputs. A scoreboard
// queue holds the words expected to be shifted.
module tb_sipo_frame_ctrl;

    localparam int WORDS = 18;
    localparam int DW    = 16;
    localparam int CW    = 5;
    localparam int FW    = WORDS * DW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] sh_data;
    logic          sh_en;
    logic          frame_valid;
    logic          frame_ready;
    logic [CW-1:0] word_cnt;
    logic [15:0]   frame_count;

    logic [DW-1:0] expQ[$];
    logic [FW-1:0] shiftReg;
    logic [FW-1:0] expFrame;
    logic [FW-1:0] frameSnap;
    int            checks;
    int            failures;
    int            shPulses;
    int            accepted;

    sipo_frame_ctrl #(.WORDS(WORDS), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .sh_data     (sh_data),
        .sh_en       (sh_en),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .word_cnt    (word_cnt),
        .frame_count (frame_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check, and on failure counts it and reports it
    task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs. Words the bench expects to be accepted are queued here
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic fr,
                                 input logic fl, input bit push);
        in_valid    = v;
        in_data     = d;
        frame_ready = fr;
        flush       = fl;
        if (push) begin
            expQ.push_back(d);
            expFrame = {d, expFrame[FW-1:DW]};
        end
        #1;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifter model and scoreboard: every sh_en pulse must match the next queued word
    always @(negedge clk) begin
        if (sh_en === 1'b1) begin
            shPulses++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_sh_en", FW'(sh_data), FW'(17'h1_0000));
            end else begin
                checkOutput("sh_data", FW'(sh_data), FW'(expQ.pop_front()));
            end
            shiftReg = {sh_data, shiftReg[FW-1:DW]};
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        shPulses = 0;
        shiftReg = '0;
        expFrame = '0;
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        frame_ready = 1'b0;

        // Reset: outputs are quiet while rst is high, and registers clear
        applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_in_ready", FW'(in_ready), FW'(0));
        checkOutput("rst_sh_en", FW'(sh_en), FW'(0));
        tick();
        tick();
        checkOutput("rst_word_cnt", FW'(word_cnt), FW'(0));
        checkOutput("rst_frame_valid", FW'(frame_valid), FW'(0));
        checkOutput("rst_frame_count", FW'(frame_count), FW'(0));
        rst = 1'b0;

        // Continuous stream 0x0001..0x0012
        for (int i = 1; i <= WORDS; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
            if (i == 1) checkOutput("t1_in_ready", FW'(in_ready), FW'(1));
            tick();
            if (i < WORDS) checkOutput("t1_word_cnt", FW'(word_cnt), FW'(i));
        end
        checkOutput("t1_pulses", FW'(shPulses), FW'(18));
        checkOutput("t1_frame_valid", FW'(frame_valid), FW'(1));
        checkOutput("t1_word_cnt_full", FW'(word_cnt), FW'(18));
        checkOutput("t1_bottom_word", FW'(shiftReg[15:0]), FW'(16'h0001));
        checkOutput("t1_top_word", FW'(shiftReg[287:272]), FW'(16'h0012));
        checkOutput("t1_frame", shiftReg, expFrame);

        // Backpressure: frame held, producer ignored
        frameSnap = shiftReg;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
            checkOutput("t2_in_ready", FW'(in_ready), FW'(0));
            tick();
            checkOutput("t2_frame_valid", FW'(frame_valid), FW'(1));
        end
        checkOutput("t2_frame_stable", shiftReg, frameSnap);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t2_fv_cleared", FW'(frame_valid), FW'(0));
        checkOutput("t2_word_cnt", FW'(word_cnt), FW'(0));
        checkOutput("t2_frame_count", FW'(frame_count), FW'(1));

        // Bubbled input: valid pattern 1,0,0 repeated
        accepted = 0;
        for (int c = 0; accepted < WORDS; c++) begin
            if (c % 3 == 0) begin
                applyStimulus(1'b1, DW'(16'h0100 + accepted), 1'b0, 1'b0, 1'b1);
                if (c == 0) checkOutput("t2_in_ready_next", FW'(in_ready), FW'(1));
                accepted++;
            end else begin
                applyStimulus(1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
            end
            tick();
            checkOutput("t3_word_cnt", FW'(word_cnt), FW'(accepted));
        end
        checkOutput("t3_frame_valid", FW'(frame_valid), FW'(1));
        checkOutput("t3_frame", shiftReg, expFrame);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t3_frame_count", FW'(frame_count), FW'(2));

        // Flush mid-fill after 7 words
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("t4_word_cnt_7", FW'(word_cnt), FW'(7));
        applyStimulus(1'b1, 16'h0BAD, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_in_ready", FW'(in_ready), FW'(0));
        checkOutput("t4_sh_en", FW'(sh_en), FW'(0));
        tick();
        checkOutput("t4_word_cnt_0", FW'(word_cnt), FW'(0));
        for (int i = 0; i < WORDS; i++) begin
            applyStimulus(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0, 1'b1);
            tick();
            if (i == WORDS - 2) checkOutput("t4_not_full_17", FW'(frame_valid), FW'(0));
        end
        checkOutput("t4_frame_valid", FW'(frame_valid), FW'(1));
        checkOutput("t4_frame", shiftReg, expFrame);
        checkOutput("t4_frame_count", FW'(frame_count), FW'(2));

        // Flush colliding with handoff
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t5_frame_valid", FW'(frame_valid), FW'(0));
        checkOutput("t5_word_cnt", FW'(word_cnt), FW'(0));
        checkOutput("t5_frame_count", FW'(frame_count), FW'(2));

        // Reset mid-fill with word_cnt=11
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, DW'(16'h0400 + i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("t6_word_cnt_11", FW'(word_cnt), FW'(11));
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0C0C, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_rst_in_ready", FW'(in_ready), FW'(0));
        tick();
        rst = 1'b0;
        checkOutput("t6_word_cnt", FW'(word_cnt), FW'(0));
        checkOutput("t6_frame_valid", FW'(frame_valid), FW'(0));
        checkOutput("t6_frame_count", FW'(frame_count), FW'(0));

        // frame_count wrap: preload 0xFFFF, then one handoff
        for (int i = 0; i < WORDS; i++) begin
            applyStimulus(1'b1, DW'(16'h0500 + i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("t6_full", FW'(frame_valid), FW'(1));
        checkOutput("t6_frame", shiftReg, expFrame);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        force dut.r_frameCount = 16'hFFFF;
        tick();
        release dut.r_frameCount;
        #1;
        checkOutput("t6_preload", FW'(frame_count), FW'(16'hFFFF));
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t6_wrap", FW'(frame_count), FW'(16'h0000));
        checkOutput("t6_wrap_fv", FW'(frame_valid), FW'(0));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();

        checkOutput("scoreboard_empty", FW'(expQ.size()), FW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
